// File: rtl/dmem_responder_pkg.sv
// Shared constants and FSM state encoding for the memory-stage responder.
package dmem_responder_pkg;

  localparam int DEF_INDEX_W    = 6;
  localparam int DEF_MEM_ADDR_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_tag_store.sv
// Flop-based direct-mapped line store: valid/tag/data per line,
// combinational lookup and a single write port.
module dmem_tag_store #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 12
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [INDEX_W-1:0] lookup_index_i,
  input  logic [TAG_W-1:0]   lookup_tag_i,
  output logic               hit_o,
  output logic [31:0]        rdata_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [31:0]        wr_data_i,
  input  logic               wr_set_valid_i
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      // Valid bit: cleared by reset, set only by a refill.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          valid_q[gi] <= 1'b0;
        end else if (wr_en_i && wr_set_valid_i && (wr_index_i == INDEX_W'(gi))) begin
          valid_q[gi] <= 1'b1;
        end
      end

      // Tag/data: data written on every write, tag only when the line is (re)allocated.
      always_ff @(posedge clk) begin
        if (wr_en_i && (wr_index_i == INDEX_W'(gi))) begin
          data_q[gi] <= wr_data_i;
          if (wr_set_valid_i) begin
            tag_q[gi] <= wr_tag_i;
          end
        end
      end
    end
  endgenerate

  assign hit_o   = valid_q[lookup_index_i] && (tag_q[lookup_index_i] == lookup_tag_i);
  assign rdata_o = data_q[lookup_index_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: write-through, no-write-allocate, one-word-line
// cache in front of a req/ack backing port, stalling the pipeline on misses
// and stores.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int INDEX_W    = DEF_INDEX_W,
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  memread_mem,
  input  logic                  memwrite_mem,
  input  logic [31:0]           alu_result_mem,
  input  logic [31:0]           write_data_memory_mem,
  input  logic                  alu_ready,
  output logic                  data_ready_mem,
  output logic [31:0]           data_from_memory_mem,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int TAG_W = MEM_ADDR_W - INDEX_W;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           resp_q, resp_d;
  logic [31:0]           hit_count_q, hit_count_d;
  logic [31:0]           miss_count_q, miss_count_d;

  logic [MEM_ADDR_W-1:0] req_waddr;
  logic [MEM_ADDR_W-1:0] lookup_addr;
  logic                  ts_hit;
  logic [31:0]           ts_rdata;
  logic                  ts_wr_en;
  logic                  ts_set_valid;
  logic [31:0]           ts_wr_data;

  // Byte offset and high address bits are not part of the word address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{alu_result_mem[31:MEM_ADDR_W+2], alu_result_mem[1:0]};

  assign req_waddr = alu_result_mem[MEM_ADDR_W+1:2];
  // Outside IDLE the lookup follows the in-flight address so the
  // write-through tag check does not depend on the stalled request inputs.
  assign lookup_addr = (state_q == ST_IDLE) ? req_waddr : mem_addr_q;

  dmem_tag_store #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_tag_store (
    .clk           (clk),
    .rstn          (rstn),
    .lookup_index_i(lookup_addr[INDEX_W-1:0]),
    .lookup_tag_i  (lookup_addr[MEM_ADDR_W-1:INDEX_W]),
    .hit_o         (ts_hit),
    .rdata_o       (ts_rdata),
    .wr_en_i       (ts_wr_en),
    .wr_index_i    (mem_addr_q[INDEX_W-1:0]),
    .wr_tag_i      (mem_addr_q[MEM_ADDR_W-1:INDEX_W]),
    .wr_data_i     (ts_wr_data),
    .wr_set_valid_i(ts_set_valid)
  );

  // Next-state, backing-port, line-write and pipeline-handshake logic.
  always_comb begin
    state_d              = state_q;
    mem_req_d            = mem_req_q;
    mem_we_d             = mem_we_q;
    mem_addr_d           = mem_addr_q;
    mem_wdata_d          = mem_wdata_q;
    resp_d               = resp_q;
    hit_count_d          = hit_count_q;
    miss_count_d         = miss_count_q;
    ts_wr_en             = 1'b0;
    ts_set_valid         = 1'b0;
    ts_wr_data           = mem_wdata_q;
    data_ready_mem       = 1'b0;
    data_from_memory_mem = 32'd0;

    unique case (state_q)
      ST_IDLE: begin
        data_ready_mem = 1'b1;
        if (memwrite_mem) begin
          // Store wins over a simultaneous load flag.
          data_ready_mem = 1'b0;
          state_d        = ST_WR_THRU;
          mem_req_d      = 1'b1;
          mem_we_d       = 1'b1;
          mem_addr_d     = req_waddr;
          mem_wdata_d    = write_data_memory_mem;
        end else if (memread_mem) begin
          if (ts_hit) begin
            data_from_memory_mem = ts_rdata;
            if (alu_ready) begin
              hit_count_d = hit_count_q + 32'd1;
            end
          end else begin
            data_ready_mem = 1'b0;
            state_d        = ST_RD_MISS;
            mem_req_d      = 1'b1;
            mem_we_d       = 1'b0;
            mem_addr_d     = req_waddr;
            miss_count_d   = miss_count_q + 32'd1;
          end
        end
      end
      ST_RD_MISS: begin
        if (mem_ack) begin
          ts_wr_en     = 1'b1;
          ts_set_valid = 1'b1;
          ts_wr_data   = mem_rdata;
          resp_d       = mem_rdata;
          mem_req_d    = 1'b0;
          state_d      = ST_DONE;
        end
      end
      ST_WR_THRU: begin
        if (mem_ack) begin
          // No allocate: only refresh a line already holding this address.
          ts_wr_en  = ts_hit;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        data_ready_mem       = 1'b1;
        data_from_memory_mem = resp_q;
        if (alu_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      resp_q       <= 32'd0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_q       <= resp_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder with a hand-driven
// backing-memory ack and a few hand-written reset/hold sequences.
module tb_dmem_responder;

  logic        clk;
  logic        rstn;
  logic        memread_mem;
  logic        memwrite_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_memory_mem;
  logic        alu_ready;
  logic        data_ready_mem;
  logic [31:0] data_from_memory_mem;
  logic        mem_req;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks;
  int failures;

  dmem_responder dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .memread_mem          (memread_mem),
    .memwrite_mem         (memwrite_mem),
    .alu_result_mem       (alu_result_mem),
    .write_data_memory_mem(write_data_memory_mem),
    .alu_ready            (alu_ready),
    .data_ready_mem       (data_ready_mem),
    .data_from_memory_mem (data_from_memory_mem),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_ack              (mem_ack),
    .mem_rdata            (mem_rdata),
    .hit_count            (hit_count),
    .miss_count           (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    int          hold;
    int          exp_stalls;
    logic        chk_data;
    logic [31:0] exp_data;
    int          exp_reqs;
    logic [17:0] exp_addr;
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  vec_t vecs[14];

  int          got_stalls;
  int          got_reqs;
  logic [31:0] got_data;
  logic [17:0] got_addr;
  logic        got_we;
  logic [31:0] got_wdata;
  logic        got_unstable;
  logic        got_timeout;
  logic        got_hold_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drives one request and plays the backing memory: ack on the lat-th
  // cycle of mem_req. Optionally holds alu_ready low in the response cycle.
  task automatic run_access(input vec_t v);
    int   reqc;
    logic prev_req;
    logic done;
    got_stalls   = 0;
    got_reqs     = 0;
    got_data     = 32'd0;
    got_addr     = '0;
    got_we       = 1'b0;
    got_wdata    = 32'd0;
    got_unstable = 1'b0;
    got_timeout  = 1'b0;
    got_hold_bad = 1'b0;
    reqc         = 0;
    prev_req     = 1'b0;
    done         = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      mem_ack               = 1'b0;
      memread_mem           = v.rd;
      memwrite_mem          = v.wr;
      alu_result_mem        = v.addr;
      write_data_memory_mem = v.wdata;
      alu_ready             = 1'b1;
      #1;
      if (mem_req) begin
        if (!prev_req) got_reqs++;
        reqc++;
        if (reqc == 1) begin
          got_addr  = mem_addr;
          got_we    = mem_we;
          got_wdata = mem_wdata;
        end else if (mem_addr !== got_addr || mem_we !== got_we || mem_wdata !== got_wdata) begin
          got_unstable = 1'b1;
        end
        if (reqc == v.lat) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      prev_req = mem_req;
      if (data_ready_mem) begin
        done     = 1'b1;
        got_data = data_from_memory_mem;
      end else begin
        got_stalls++;
      end
    end
    if (!done) got_timeout = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      alu_ready = 1'b0;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      if (!data_ready_mem || data_from_memory_mem !== got_data || mem_req) got_hold_bad = 1'b1;
    end
    alu_ready = 1'b1;
  endtask

  // One bubble cycle with no request; counters reflect the consuming edge.
  task automatic idle_cycle();
    @(negedge clk);
    mem_ack      = 1'b0;
    memread_mem  = 1'b0;
    memwrite_mem = 1'b0;
    alu_ready    = 1'b1;
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    $display("vec %0d rd=%0b wr=%0b addr=0x%08h stalls=%0d data=0x%08h reqs=%0d hits=%0d misses=%0d",
             i, v.rd, v.wr, v.addr, got_stalls, got_data, got_reqs, hit_count, miss_count);
    check($sformatf("v%0d_timeout", i), 32'(got_timeout), 32'd0);
    check($sformatf("v%0d_stalls", i), 32'(got_stalls), 32'(v.exp_stalls));
    check($sformatf("v%0d_reqs", i), 32'(got_reqs), 32'(v.exp_reqs));
    if (v.chk_data) check($sformatf("v%0d_data", i), got_data, v.exp_data);
    if (v.exp_reqs > 0) begin
      check($sformatf("v%0d_addr", i), 32'(got_addr), 32'(v.exp_addr));
      check($sformatf("v%0d_we", i), 32'(got_we), 32'(v.wr));
      if (v.wr) check($sformatf("v%0d_wdata", i), got_wdata, v.wdata);
      check($sformatf("v%0d_stable", i), 32'(got_unstable), 32'd0);
    end
    if (v.hold > 0) check($sformatf("v%0d_hold", i), 32'(got_hold_bad), 32'd0);
    check($sformatf("v%0d_req_idle", i), 32'(mem_req), 32'd0);
    check($sformatf("v%0d_ready_idle", i), 32'(data_ready_mem), 32'd1);
    check($sformatf("v%0d_hits", i), hit_count, 32'(v.exp_hits));
    check($sformatf("v%0d_misses", i), miss_count, 32'(v.exp_misses));
  endtask

  initial begin
    vec_t rv;
    checks   = 0;
    failures = 0;

    //            rd    wr    addr          wdata         lat rdata         hold stl chk   exp_data      reqs addr      hit mis
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        3, 32'hDEAD_BEEF, 0,   4,  1'b1, 32'hDEAD_BEEF, 1, 18'h00010, 0, 1};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1, 32'h0,         0,   0,  1'b1, 32'hDEAD_BEEF, 0, 18'h0,     1, 1};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678,1, 32'h0,         0,   2,  1'b0, 32'h0,         1, 18'h00010, 1, 1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1, 32'h0,         0,   0,  1'b1, 32'h1234_5678, 0, 18'h0,     2, 1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        2, 32'hCAFE_F00D, 5,   3,  1'b1, 32'hCAFE_F00D, 1, 18'h00020, 2, 2};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        1, 32'h0,         0,   0,  1'b1, 32'hCAFE_F00D, 0, 18'h0,     3, 2};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0140, 32'h0,        1, 32'h0BAD_C0DE, 0,   2,  1'b1, 32'h0BAD_C0DE, 1, 18'h00050, 3, 3};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0142, 32'h0,        1, 32'h0,         0,   0,  1'b1, 32'h0BAD_C0DE, 0, 18'h0,     4, 3};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1, 32'h1234_5678, 0,   2,  1'b1, 32'h1234_5678, 1, 18'h00010, 4, 4};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0240, 32'hA5A5_A5A5,2, 32'h0,         0,   3,  1'b0, 32'h0,         1, 18'h00090, 4, 4};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1, 32'h0,         0,   0,  1'b1, 32'h1234_5678, 0, 18'h0,     5, 4};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0240, 32'h0,        1, 32'h55AA_55AA, 0,   2,  1'b1, 32'h55AA_55AA, 1, 18'h00090, 5, 5};
    vecs[12] = '{1'b1, 1'b1, 32'h0000_0080, 32'h7777_8888,1, 32'h0,         0,   2,  1'b0, 32'h0,         1, 18'h00020, 5, 5};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        1, 32'h0,         0,   0,  1'b1, 32'h7777_8888, 0, 18'h0,     6, 5};

    rstn                  = 1'b0;
    memread_mem           = 1'b0;
    memwrite_mem          = 1'b0;
    alu_result_mem        = 32'd0;
    write_data_memory_mem = 32'd0;
    alu_ready             = 1'b1;
    mem_ack               = 1'b0;
    mem_rdata             = 32'd0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;

    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ready", 32'(data_ready_mem), 32'd1);
    check("rst_data", data_from_memory_mem, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_access(vecs[i]);
      idle_cycle();
      check_vec(i, vecs[i]);
    end

    // Reset while a read miss is waiting for its ack; late ack must be ignored.
    @(negedge clk);
    memread_mem    = 1'b1;
    alu_result_mem = 32'h0000_0400;
    alu_ready      = 1'b1;
    #1;
    @(negedge clk);
    #1;
    check("rstmid_req_before", 32'(mem_req), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    memread_mem = 1'b0;
    #1;
    check("rstmid_req_after", 32'(mem_req), 32'd0);
    check("rstmid_hits", hit_count, 32'd0);
    check("rstmid_misses", miss_count, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_ready", 32'(data_ready_mem), 32'd1);
    check("late_ack_data", data_from_memory_mem, 32'd0);
    $display("reset mid-miss: mem_req=%0b ready=%0b hits=%0d misses=%0d",
             mem_req, data_ready_mem, hit_count, miss_count);

    // Valid bits cleared: a previously cached address must miss again.
    rv = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678, 0, 2, 1'b1, 32'h1234_5678, 1, 18'h00010, 0, 1};
    run_access(rv);
    idle_cycle();
    check_vec(14, rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-stage responder for the 5-stage core. It serves the load/store request held in the EX/MEM register and drives data_ready_mem, which stalls every pipeline register and the PC while it is low. It also produces data_from_memory_mem, which MEM/WB latches on data_ready_mem && alu_ready. A direct-mapped, write-through, no-write-allocate cache of one-word lines sits in front of a req/ack backing-memory port.

Parameters:
INDEX_W, 6, log2 of cache lines (64 lines x 32 bits, flop-based)
MEM_ADDR_W, 18, word-address width of backing port; tag width = MEM_ADDR_W - INDEX_W

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
memread_mem  in  1  load request from EX/MEM
memwrite_mem  in  1  store request from EX/MEM
alu_result_mem  in  32  byte address; bits [1:0] ignored; word addr = [MEM_ADDR_W+1:2]
write_data_memory_mem  in  32  store data
alu_ready  in  1  ALU not stalling; response consumed when data_ready_mem && alu_ready
data_ready_mem  out  1  0 = stall pipeline
data_from_memory_mem  out  32  load data, valid while data_ready_mem=1 for a load
mem_req  out  1  backing request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  MEM_ADDR_W  word address
mem_wdata  out  32  write data
mem_ack  in  1  one-cycle completion pulse
mem_rdata  in  32  read data, valid in the mem_ack cycle
hit_count  out  32  load hits
miss_count  out  32  load misses

Behaviour:
- States: IDLE, RD_MISS, WR_THRU, DONE. Encoding is 2 bits.
- Reset: state IDLE, all valid bits 0, mem_req/mem_we 0, mem_addr/mem_wdata 0, response register 0, counters 0.
- Reset takes priority in every state. An in-flight request is abandoned, mem_req drops the next cycle, and a late mem_ack is ignored.
- data_ready_mem (combinational):
  - 1 in IDLE when there is no request or the request is a load hit.
  - 0 in IDLE on a load miss or any store.
  - 0 in RD_MISS and WR_THRU.
  - 1 in DONE.
- data_from_memory_mem:
  - IDLE load hit: cache data, combinational.
  - DONE: response register.
  - Otherwise: 0.
- Lookup: index = word addr[INDEX_W-1:0], tag = upper bits. hit = valid[index] && tag match.
- IDLE, load hit: no state change, zero stall. hit_count increments once, on the consuming edge (alu_ready=1).
- IDLE, load miss: go to RD_MISS. mem_req=1, mem_we=0, mem_addr registered. miss_count increments.
- IDLE, store (memwrite_mem=1, regardless of memread_mem; store wins): go to WR_THRU. mem_req=1, mem_we=1, mem_addr and mem_wdata registered.
- RD_MISS, mem_ack: write mem_rdata into the line, set valid and tag, load the response register, go to DONE, drop mem_req.
- WR_THRU, mem_ack: if the line holds the same tag, update its data (no allocate on miss), go to DONE, drop mem_req.
- mem_req/mem_addr/mem_wdata stay stable from assertion until the mem_ack cycle. mem_ack outside RD_MISS/WR_THRU is ignored.
- DONE: data_ready_mem=1. Go to IDLE when alu_ready=1. If alu_ready=0, stay in DONE and hold the response stable. The unchanged EX/MEM request is not re-served.
- Latency:
  - Load hit: 0 stall cycles.
  - Load miss with ack latency A (A>=1 cycles after mem_req rises): request seen at cycle 0, mem_req high cycles 1..A, DONE at cycle A+1. Minimum 2 stall cycles.
  - Store: same timing as a load miss.
- Counters wrap at 2^32.
- Same-index load after store: WR_THRU updates the line before DONE, so the following load hits with the new data.

Decomposition:
- Shared package/include: state encodings (ST_IDLE=0, ST_RD_MISS=1, ST_WR_THRU=2, ST_DONE=3) and the default INDEX_W/MEM_ADDR_W constants.
- One sub-module: dmem_tag_store. It holds valid/tag/data flops, exposes combinational lookup (hit, rdata), and has a single write port (index, tag, data, set_valid). The FSM, backing port and counters stay in dmem_responder.

Test Plan:
- Cold load addr 0x0000_0040, mem_rdata=0xDEADBEEF, ack 3 cycles after mem_req -> data_ready_mem=0 for 4 cycles, then 1 with data 0xDEADBEEF; miss_count=1.
- Repeat load 0x40 with alu_ready=1 -> data_ready_mem=1 the same cycle, data 0xDEADBEEF, no mem_req; hit_count=1.
- Store 0x1234_5678 to 0x40 (ack after 1 cycle), then load 0x40 -> mem_req/mem_we=1 with mem_addr=0x10, 2 stall cycles; the following load hits with 0x12345678.
- Load miss completes while alu_ready=0 for 5 cycles -> stays in DONE, data_ready_mem=1, data stable, exactly one mem_req transaction, returns to IDLE on alu_ready=1.
- Aliasing: load 0x40 then load 0x40 + (64<<2) -> second load misses and refills; a third load of 0x40 misses again.
- rstn=0 during RD_MISS before ack, late mem_ack after release -> mem_req=0 the cycle after reset, state IDLE, valid bits clear, counters 0, late ack ignored.
